aes_axil_regfile: RTL

AES_AXIL_REGFILE -- requirements
Module: aes_axil_regfile

---
 rtl/aes_axil_pkg.sv | 51 +++++
 rtl/aes_axil_decode.sv | 48 ++++
 rtl/aes_axil_regfile.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/aes_axil_pkg.sv
// Register map, response codes and field encodings for the AES AXI4-Lite register file.
package aes_axil_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_MODE   = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_KEY    = 8'h10;
    localparam logic [7:0] OFF_DIN    = 8'h20;
    localparam logic [7:0] OFF_IV     = 8'h30;
    localparam logic [7:0] OFF_DOUT   = 8'h40;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_ENC_DEC_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0]  MODE_ECB  = 3'd0;
    localparam logic [2:0]  MODE_CBC  = 3'd1;
    localparam logic [2:0]  MODE_CTR  = 3'd2;
    localparam logic [31:0] MODE_MASK = 32'h0000_0007;

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_RO   = 2'd1;
    localparam logic [1:0] ACC_RW   = 2'd2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_MODE,
        SEL_STATUS,
        SEL_KEY,
        SEL_DIN,
        SEL_IV,
        SEL_DOUT
    } reg_sel_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_axil_decode.sv
// Combinational address decode: byte address -> register select, bank word and access class.
// Address bits [1:0] are ignored; anything outside the map decodes to ACC_NONE.
module aes_axil_decode
    import aes_axil_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [2:0]        reg_sel,
    output logic [1:0]        word_idx,
    output logic [1:0]        acc
);

    logic [29:0] wa;
    reg_sel_e    sel;

    assign wa       = 30'(addr >> 2);
    assign word_idx = wa[1:0];
    assign reg_sel  = sel;

    always_comb begin
        sel = SEL_NONE;
        acc = ACC_NONE;
        if (wa[29:5] == '0) begin
            case (wa[4:2])
                3'd0: begin
                    case (wa[1:0])
                        2'd0:    sel = SEL_CTRL;
                        2'd1:    sel = SEL_MODE;
                        2'd2:    sel = SEL_STATUS;
                        default: sel = SEL_NONE;
                    endcase
                end
                3'd1:    sel = SEL_KEY;
                3'd2:    sel = SEL_DIN;
                3'd3:    sel = SEL_IV;
                3'd4:    sel = SEL_DOUT;
                default: sel = SEL_NONE;
            endcase
        end
        case (sel)
            SEL_NONE:            acc = ACC_NONE;
            SEL_STATUS, SEL_DOUT: acc = ACC_RO;
            default:             acc = ACC_RW;
        endcase
    end

endmodule

// File: rtl/aes_axil_regfile.sv
// AXI4-Lite register file for the AES core; write commits when AW and W are both held, B one cycle later.
// Read data registered at AR handshake, R one cycle later; each channel holds its response until ready.
module aes_axil_regfile
    import aes_axil_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [DATA_W-1:0]   ctrl_reg,
    output logic [DATA_W-1:0]   mode_reg,
    output logic [DATA_W-1:0]   base_key_reg [0:3],
    output logic [DATA_W-1:0]   data_in_mem  [0:3],
    output logic [DATA_W-1:0]   iv_in        [0:3],
    input  logic [DATA_W-1:0]   status_reg,
    input  logic [DATA_W-1:0]   data_out_mem [0:3]
);

    localparam logic W_IDLE = 1'b0;
    localparam logic W_RESP = 1'b1;
    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    logic                rst_done;
    logic                w_state;
    logic                r_state;
    logic                aw_held;
    logic                w_held;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [DATA_W/8-1:0] w_strb_q;

    logic                aw_fire;
    logic                w_fire;
    logic                ar_fire;
    logic                do_wr;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_strb;
    logic [2:0]          wr_sel;
    logic [1:0]          wr_word;
    logic [1:0]          wr_acc;
    logic [2:0]          rd_sel;
    logic [1:0]          rd_word;
    logic [1:0]          rd_acc;
    logic [DATA_W-1:0]   rd_val;

    // Readies stay low until one full clock after reset is released.
    assign s_awready = rst_done && !aw_held && (w_state == W_IDLE);
    assign s_wready  = rst_done && !w_held  && (w_state == W_IDLE);
    assign s_arready = rst_done && (r_state == R_IDLE);
    assign s_bvalid  = (w_state == W_RESP);
    assign s_rvalid  = (r_state == R_DATA);

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid && s_wready;
    assign ar_fire = s_arvalid && s_arready;

    assign wr_addr = aw_held ? aw_addr_q : s_awaddr;
    assign wr_data = w_held  ? w_data_q  : s_wdata;
    assign wr_strb = w_held  ? w_strb_q  : s_wstrb;
    assign do_wr   = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_en   = do_wr && (wr_acc == ACC_RW);

    aes_axil_decode #(.ADDR_W(ADDR_W)) u_wr_decode (
        .addr     (wr_addr),
        .reg_sel  (wr_sel),
        .word_idx (wr_word),
        .acc      (wr_acc)
    );

    aes_axil_decode #(.ADDR_W(ADDR_W)) u_rd_decode (
        .addr     (s_araddr),
        .reg_sel  (rd_sel),
        .word_idx (rd_word),
        .acc      (rd_acc)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rst_done  <= 1'b0;
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            s_bresp   <= RESP_OKAY;
        end else begin
            rst_done <= 1'b1;
            case (w_state)
                W_IDLE: begin
                    if (do_wr) begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        s_bresp <= (wr_acc == ACC_RW) ? RESP_OKAY : RESP_SLVERR;
                        w_state <= W_RESP;
                    end else begin
                        if (aw_fire) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= s_awaddr;
                        end
                        if (w_fire) begin
                            w_held   <= 1'b1;
                            w_data_q <= s_wdata;
                            w_strb_q <= s_wstrb;
                        end
                    end
                end
                default: begin
                    if (s_bready) w_state <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_reg <= '0;
            mode_reg <= '0;
            for (int i = 0; i < 4; i++) begin
                base_key_reg[i] <= '0;
                data_in_mem[i]  <= '0;
                iv_in[i]        <= '0;
            end
        end else if (wr_en) begin
            case (wr_sel)
                SEL_CTRL: ctrl_reg <= apply_strb(ctrl_reg, wr_data, wr_strb);
                SEL_MODE: mode_reg <= apply_strb(mode_reg, wr_data, wr_strb) & MODE_MASK;
                SEL_KEY:  base_key_reg[wr_word] <= apply_strb(base_key_reg[wr_word], wr_data, wr_strb);
                SEL_DIN:  data_in_mem[wr_word]  <= apply_strb(data_in_mem[wr_word], wr_data, wr_strb);
                SEL_IV:   iv_in[wr_word]        <= apply_strb(iv_in[wr_word], wr_data, wr_strb);
                default:  ;
            endcase
        end
    end

    // Sampled before the write path's update lands, so a same-cycle read sees the old value.
    always_comb begin
        rd_val = '0;
        case (rd_sel)
            SEL_CTRL:   rd_val = ctrl_reg;
            SEL_MODE:   rd_val = mode_reg;
            SEL_STATUS: rd_val = status_reg;
            SEL_KEY:    rd_val = base_key_reg[rd_word];
            SEL_DIN:    rd_val = data_in_mem[rd_word];
            SEL_IV:     rd_val = iv_in[rd_word];
            SEL_DOUT:   rd_val = data_out_mem[rd_word];
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            s_rdata <= '0;
            s_rresp <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        s_rdata <= rd_val;
                        s_rresp <= (rd_acc == ACC_NONE) ? RESP_SLVERR : RESP_OKAY;
                        r_state <= R_DATA;
                    end
                end
                default: begin
                    if (s_rready) r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule
